// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle for the multiply/divide unit.
// master drives start/op/a/b; slave returns busy/done/div_zero/hi/lo.
interface mult_div_unit_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed 32-bit MULT (Booth radix-2) / DIV (restoring) unit.
// Ports: clk, reset_n (async low), bus (slave: start/op/a/b -> busy/done/div_zero/hi/lo).
module mult_div_unit (
  input  logic           clk,
  input  logic           reset_n,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic        accept;
  logic        zdiv;
  logic [4:0]  cnt;

  logic        op_q;
  logic        qsign;
  logic        rsign;
  logic        zflag;

  logic [31:0] mcand;
  logic [31:0] dvsr;
  logic [31:0] rem;
  logic [31:0] quo;

  // Booth register: 33-bit upper half, 32-bit lower half, q-1.
  // The extra upper bit keeps P_hi -/+ mcand from overflowing
  // when the multiplicand is 0x80000000.
  logic [65:0] prod;

  logic        busy_q;
  logic        done_q;
  logic        dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [32:0] ph;
  logic [32:0] ph_nx;
  logic [65:0] prod_nx;

  logic [32:0] r_sh;
  logic [32:0] diff;

  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  assign a_mag = bus.a[31] ? -bus.a : bus.a;
  assign b_mag = bus.b[31] ? -bus.b : bus.b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    zdiv     = bus.op && (bus.b == 32'd0);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = zdiv ? FIN : RUN;
        end
      end
      RUN: begin
        if (cnt == 5'd31) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    ph = prod[65:33];
    unique case (prod[1:0])
      2'b01:   ph_nx = ph + {mcand[31], mcand};
      2'b10:   ph_nx = ph - {mcand[31], mcand};
      default: ph_nx = ph;
    endcase
    prod_nx = 66'($signed({ph_nx, prod[32:0]}) >>> 1);
  end

  // Partial remainder stays below the divisor (<= 2^31),
  // so the shifted value fits in 33 bits and diff[32]
  // is the borrow of the trial subtraction.
  always_comb begin
    r_sh = {rem, quo[31]};
    diff = r_sh - {1'b0, dvsr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      op_q   <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      zflag  <= 1'b0;
      mcand  <= '0;
      dvsr   <= '0;
      rem    <= '0;
      quo    <= '0;
      prod   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q   <= bus.op;
        zflag  <= zdiv;
        mcand  <= bus.a;
        prod   <= {33'd0, bus.b, 1'b0};
        dvsr   <= b_mag;
        rem    <= '0;
        quo    <= a_mag;
        qsign  <= bus.a[31] ^ bus.b[31];
        rsign  <= bus.a[31];
        dz_q   <= 1'b0;
        busy_q <= 1'b1;
        cnt    <= '0;
      end
      if (state == RUN) begin
        cnt <= cnt + 5'd1;
        if (op_q) begin
          if (diff[32]) begin
            rem <= r_sh[31:0];
            quo <= {quo[30:0], 1'b0};
          end else begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end
        end else begin
          prod <= prod_nx;
        end
      end
      if (state == FIN) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        if (zflag) begin
          dz_q <= 1'b1;
        end else if (op_q) begin
          lo_q <= qsign ? -quo : quo;
          hi_q <= rsign ? -rem : rem;
        end else begin
          hi_q <= prod[64:33];
          lo_q <= prod[32:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: MULT/DIV results, latency,
// div-by-zero, start-while-busy, mid-run reset, back-to-back.
module tb_mult_div_unit;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op, follows it to done (bounded), returns observations.
  task automatic run_op(
    input  logic        o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  int          inj,
    input  int          post,
    output int          lat,
    output int          nd,
    output int          bc,
    output logic        b0,
    output logic        d0,
    output logic        z0
  );
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = ~o;
    b0  = bus.busy;
    d0  = bus.done;
    z0  = bus.div_zero;
    bc  = b0 ? 1 : 0;
    lat = 0;
    nd  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy) bc++;
      bus.start = 1'b0;
      if (k == inj) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end
      if (bus.done) begin
        nd++;
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    for (int p = 0; p < post; p++) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    total++;
    if (bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_dz got=%b exp=0", bus.div_zero);
    end
    total++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_hilo got=%h_%h exp=0_0", bus.hi, bus.lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult;
    int   lat, nd, bc;
    logic b0, d0, z0;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 0, 3, lat, nd, bc, b0, d0, z0);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL mult_latency got=%0d exp=33", lat);
    end
    total++;
    if (b0 !== 1'b1 || bc !== 33) begin
      bad++;
      $display("FAIL mult_busy got=%b/%0d exp=1/33", b0, bc);
    end
    total++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin
      bad++;
      $display("FAIL mult_7x-3 got=%h_%h exp=ffffffff_ffffffeb",
               bus.hi, bus.lo);
    end
    total++;
    if (bus.div_zero !== 1'b0 || nd !== 1) begin
      bad++;
      $display("FAIL mult_dz_done got=%b/%0d exp=0/1",
               bus.div_zero, nd);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL mult_idle got=%b%b exp=00", bus.busy, bus.done);
    end
  endtask

  task automatic test_div;
    int   lat, nd, bc;
    logic b0, d0, z0;
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, 1, lat, nd, bc, b0, d0, z0);
    total++;
    if (lat !== 33 || nd !== 1) begin
      bad++;
      $display("FAIL div_latency got=%0d/%0d exp=33/1", lat, nd);
    end
    total++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL div_-7/2 got=%h_%h exp=ffffffff_fffffffd",
               bus.hi, bus.lo);
    end
    run_op(1'b1, 32'd100, 32'd7, 0, 1, lat, nd, bc, b0, d0, z0);
    total++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      bad++;
      $display("FAIL div_100/7 got=%h_%h exp=00000002_0000000e",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_zero;
    int   lat, nd, bc;
    logic b0, d0, z0;
    run_op(1'b1, 32'd5, 32'd0, 0, 3, lat, nd, bc, b0, d0, z0);
    total++;
    if (lat !== 1 || nd !== 1) begin
      bad++;
      $display("FAIL dz_latency got=%0d/%0d exp=1/1", lat, nd);
    end
    total++;
    if (bc !== 1) begin
      bad++;
      $display("FAIL dz_busy_cycles got=%0d exp=1", bc);
    end
    total++;
    if (bus.div_zero !== 1'b1) begin
      bad++;
      $display("FAIL dz_flag got=%b exp=1", bus.div_zero);
    end
    total++;
    if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
      bad++;
      $display("FAIL dz_hold got=%h_%h exp=00000002_0000000e",
               bus.hi, bus.lo);
    end
    run_op(1'b0, 32'd5, 32'd6, 0, 1, lat, nd, bc, b0, d0, z0);
    total++;
    if (z0 !== 1'b0 || bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL dz_clear got=%b/%b exp=0/0", z0, bus.div_zero);
    end
    total++;
    if (bus.lo !== 32'd30 || bus.hi !== 32'd0) begin
      bad++;
      $display("FAIL mult_5x6 got=%h_%h exp=00000000_0000001e",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_corners;
    int   lat, nd, bc;
    logic b0, d0, z0;
    run_op(1'b0, 32'h80000000, 32'h80000000, 0, 1,
           lat, nd, bc, b0, d0, z0);
    total++;
    if (bus.hi !== 32'h40000000 || bus.lo !== 32'd0) begin
      bad++;
      $display("FAIL mult_min_min got=%h_%h exp=40000000_00000000",
               bus.hi, bus.lo);
    end
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1,
           lat, nd, bc, b0, d0, z0);
    total++;
    if (bus.lo !== 32'h80000000 || bus.hi !== 32'd0) begin
      bad++;
      $display("FAIL div_min_m1 got=%h_%h exp=00000000_80000000",
               bus.hi, bus.lo);
    end
    run_op(1'b0, 32'hFFFFFFFF, 32'h80000000, 0, 1,
           lat, nd, bc, b0, d0, z0);
    total++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'h80000000) begin
      bad++;
      $display("FAIL mult_m1_min got=%h_%h exp=00000000_80000000",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_start_busy;
    int   lat, nd, bc;
    logic b0, d0, z0;
    run_op(1'b0, 32'd3, 32'd4, 9, 4, lat, nd, bc, b0, d0, z0);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL busy_start_lat got=%0d exp=33", lat);
    end
    total++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
      bad++;
      $display("FAIL busy_start_res got=%h_%h exp=00000000_0000000c",
               bus.hi, bus.lo);
    end
    total++;
    if (nd !== 1) begin
      bad++;
      $display("FAIL busy_start_dones got=%0d exp=1", nd);
    end
  endtask

  task automatic test_back_to_back;
    int   lat, nd, bc;
    logic b0, d0, z0;
    run_op(1'b0, 32'd11, 32'd13, 0, 0, lat, nd, bc, b0, d0, z0);
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0, 1, lat, nd, bc, b0, d0, z0);
    total++;
    if (b0 !== 1'b1 || d0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got=%b%b exp=10", b0, d0);
    end
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL b2b_latency got=%0d exp=33", lat);
    end
    total++;
    if (bus.lo !== 32'hFFFFFFF2 || bus.hi !== 32'hFFFFFFFE) begin
      bad++;
      $display("FAIL b2b_-100/7 got=%h_%h exp=fffffffe_fffffff2",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid;
    int   lat, nd, bc;
    logic b0, d0, z0;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ctl got=%b%b%b exp=000",
               bus.busy, bus.done, bus.div_zero);
    end
    total++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++;
      $display("FAIL midrst_hilo got=%h_%h exp=0_0", bus.hi, bus.lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(1'b0, 32'd2, 32'd3, 0, 1, lat, nd, bc, b0, d0, z0);
    total++;
    if (lat !== 33 || bus.lo !== 32'd6 || bus.hi !== 32'd0) begin
      bad++;
      $display("FAIL midrst_after got=%0d/%h_%h exp=33/0_6",
               lat, bus.hi, bus.lo);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_corners();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
